// File: rtl/bin2gray_cnt.sv
// bin2gray_cnt -- registered binary/Gray pointer counter.
//
// Keeps a binary count and a Gray-coded copy of it, both loaded from the
// same next-value on the same edge, so gray_o comes straight from a
// flop and is safe to synchronise into another clock domain.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset (clears count, Gray, wrap)
//   en_i         : step the count by one this cycle
//   dir_i        : step direction, 1 = up, 0 = down (used only with en_i)
//   load_i       : load load_bin_i (wins over en_i)
//   load_bin_i   : binary value to load
//   bin_o        : registered binary count
//   gray_o       : registered Gray code of bin_o
//   gray_nxt_o   : combinational Gray code of bin_o stepped by dir_i
//   wrap_o       : registered one-cycle pulse when the count wraps
module bin2gray_cnt #(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  dir_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_bin_i,
  output logic [DATA_WIDTH-1:0] bin_o,
  output logic [DATA_WIDTH-1:0] gray_o,
  output logic [DATA_WIDTH-1:0] gray_nxt_o,
  output logic                  wrap_o
);

  localparam logic [DATA_WIDTH-1:0] C_ONE   = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] C_ZERO  = '0;
  localparam logic [DATA_WIDTH-1:0] C_ONES  = '1;

  function automatic logic [DATA_WIDTH-1:0] bin2gray(input logic [DATA_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [DATA_WIDTH-1:0] r_bin_p1;
  logic [DATA_WIDTH-1:0] r_gray_p1;
  logic                  r_wrap_p1;

  logic [DATA_WIDTH-1:0] w_bin_step;
  logic                  w_step_wrap;
  logic [DATA_WIDTH-1:0] w_bin_nxt;
  logic                  w_wrap_nxt;

  // Stage 0: candidate step and next-value selection
  always_comb begin
    w_bin_step  = dir_i ? (r_bin_p1 + C_ONE) : (r_bin_p1 - C_ONE);
    // A step wraps when it leaves the extreme value in its direction.
    w_step_wrap = dir_i ? (r_bin_p1 == C_ONES) : (r_bin_p1 == C_ZERO);
  end

  always_comb begin
    w_bin_nxt  = r_bin_p1;
    w_wrap_nxt = 1'b0;
    if (load_i) begin
      w_bin_nxt = load_bin_i;
    end else if (en_i) begin
      w_bin_nxt  = w_bin_step;
      w_wrap_nxt = w_step_wrap;
    end
  end

  // Stage 1: binary and Gray loaded together from the same next value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bin_p1  <= '0;
      r_gray_p1 <= '0;
      r_wrap_p1 <= 1'b0;
    end else begin
      r_bin_p1  <= w_bin_nxt;
      r_gray_p1 <= bin2gray(w_bin_nxt);
      r_wrap_p1 <= w_wrap_nxt;
    end
  end

  assign bin_o      = r_bin_p1;
  assign gray_o     = r_gray_p1;
  assign wrap_o     = r_wrap_p1;
  // Look-ahead ignores load/en/reset: it only answers "what would one step give".
  assign gray_nxt_o = bin2gray(w_bin_step);

endmodule

// File: doc/bin2gray_cnt.md
# bin2gray_cnt

Registered binary-to-Gray pointer counter: keeps a binary count and emits the matching Gray code from a register, so that `gray_o` never glitches and can be sent across a clock domain.
- Used as the read/write pointer source for async FIFOs and CDC counters.
- The far-domain side converts the synchronised Gray value back to binary.
- Supports up/down counting, parallel load, a wrap pulse, and a look-ahead Gray value for full/empty comparison.

## Interface
- `DATA_WIDTH`, 4, counter width in bits; legal range 1..32.

- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `en_i` in 1: advance the count by one step this cycle.
- `dir_i` in 1: count direction, 1 = up, 0 = down; sampled only when `en_i`=1.
- `load_i` in 1: load `load_bin_i` into the counter; takes priority over `en_i`.
- `load_bin_i` in DATA_WIDTH: binary value to load.
- `bin_o` out DATA_WIDTH: current binary count, registered.
- `gray_o` out DATA_WIDTH: Gray code of `bin_o`, registered (not derived combinationally from `bin_o`).
- `gray_nxt_o` out DATA_WIDTH: combinational Gray code of the value `bin_o` would step to if `en_i`=1 with the current `dir_i`.
- `wrap_o` out 1: registered one-cycle pulse, high in the cycle the counter shows a wrapped value.

## Operation
- Gray rule: `gray = bin ^ (bin >> 1)`. The MSB of the Gray code equals the MSB of the binary value.
- Next-value logic, evaluated every cycle in this priority order:
  - `rst_i`=1: `bin_o`, `gray_o` and `wrap_o` all become 0.
  - else `load_i`=1: `bin_o` ← `load_bin_i`; `gray_o` ← Gray(`load_bin_i`); `wrap_o` ← 0.
  - else `en_i`=1 and `dir_i`=1: `bin_o` ← `bin_o`+1 mod 2^W; `wrap_o` ← 1 only if the old `bin_o` was all-ones.
  - else `en_i`=1 and `dir_i`=0: `bin_o` ← `bin_o`−1 mod 2^W; `wrap_o` ← 1 only if the old `bin_o` was 0.
  - else: hold `bin_o` and `gray_o`; `wrap_o` ← 0.
- `gray_o` is loaded from Gray(`bin_nxt`) in the same edge that loads `bin_o`. The pair is therefore always consistent: `gray_o` == Gray(`bin_o`) in every cycle.
- Arithmetic is modulo 2^DATA_WIDTH. No saturation, no overflow output other than `wrap_o`.
- `gray_nxt_o` is always computed as Gray(`bin_o` ± 1) according to `dir_i`.
  - It ignores `load_i` and `en_i`.
  - It must not depend on `rst_i`.
- DATA_WIDTH=1: Gray code equals binary; the counter toggles 0↔1. `wrap_o` pulses on 1→0 when counting up and on 0→1 when counting down.
- No state machine beyond the counter register. There is no handshake; `en_i` is a single-cycle step request.

## Timing
- Latency: `load_i` or `en_i` sampled at edge N → new `bin_o`/`gray_o` visible after edge N (one cycle).
- `wrap_o` is aligned with the wrapped value, e.g. `bin_o`=0 after counting up from all-ones. It is high for exactly one cycle per wrap.
- Consecutive `gray_o` values produced by `en_i` steps (no load, no reset) differ in exactly one bit, including across the wrap.
  - A load or reset may change multiple bits; this is the caller's responsibility in a CDC context.
- Reset mid-count: on the reset edge the outputs are 0 irrespective of `en_i`/`load_i`. Counting resumes on the first edge with `rst_i`=0.
- Simultaneous `load_i` and `en_i`: the load wins. No step is applied and `wrap_o`=0.
- A direction change between steps is allowed on any cycle; each step uses the `dir_i` sampled with its own `en_i`.

## Test plan
- Reset, then `en_i`=1, `dir_i`=1 for 16 cycles (W=4) → `gray_o` sequence 1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0. `wrap_o`=1 only with the final 0. Each step differs in exactly one bit.
- From reset, `en_i`=1, `dir_i`=0 for one cycle → `bin_o`=F, `gray_o`=8, `wrap_o`=1. The next down step gives `bin_o`=E, `gray_o`=9, `wrap_o`=0.
- `load_i`=1 with `load_bin_i`=A and `en_i`=1 in the same cycle → `bin_o`=A, `gray_o`=F, `wrap_o`=0. With `bin_o`=A, `dir_i`=1, `gray_nxt_o`=E.
- Count up to `bin_o`=5, then assert `rst_i` together with `en_i` → next cycle `bin_o`=0, `gray_o`=0, `wrap_o`=0. With `en_i` still high after reset release, `gray_o`=1 one cycle later.
- `en_i`=0 for 10 cycles at `bin_o`=7 → `bin_o`=7, `gray_o`=4 held, `wrap_o`=0 throughout.
- DATA_WIDTH=1, `dir_i`=1, `en_i`=1 → `gray_o` toggles 1,0,1,0; `wrap_o`=1 on each 0.
